parking_controller: RTL
=======================

# parking_controller

Parametrised N-slot parking-lot controller: successor to the fixed 4-slot parking top. It tracks a per-slot occupancy bitmap and allocates the lowest free slot on each entry. It frees the slot selected by the exit switches on each exit. It times the door-open light and a full-lot alarm in divider ticks, and reports free count and best (lowest free) place for the seven-segment path. It sits between the frequency divider and the display/LED outputs, replacing the hard-wired FSM and glue gates.

## Interface
Parameters:
- N_SLOTS, 4: number of parking slots (2..16).
- DOOR_TICKS, 4: tick_en pulses the door light stays on after a valid entry/exit.
- ALARM_TICKS, 6: tick_en pulses the full alarm stays on after a refused entry.
- Derived: IDX_W = $clog2(N_SLOTS); CNT_W = $clog2(N_SLOTS+1).

Ports:
- clk  in  1  system clock (40 MHz domain).
- reset  in  1  synchronous, active-high.
- tick_en  in  1  one-clk-wide timebase pulse from the divider (e.g. 2 Hz).
- entry_sensor  in  1  car at entry gate; level, already synchronised.
- exit_sensor  in  1  car at exit gate; level, already synchronised.
- exit_slot  in  IDX_W  slot being vacated, sampled on exit event.
- parking_slots  out  N_SLOTS  occupancy bitmap, 1 = occupied.
- door_open_light  out  1  door open indicator.
- full_light  out  1  refused-entry alarm.
- capacity  out  CNT_W  free slot count.
- best_place  out  IDX_W  lowest-index free slot; 0 when none.
- best_valid  out  1  at least one free slot.
- exit_error  out  1  one-cycle pulse: exit of an already-free or out-of-range slot.

## Operation
- Edge detect: each sensor is registered (`*_q`). An event occurs when sensor=1 and `*_q`=0 at a clk edge. A held sensor produces exactly one event.
- Exit event: if exit_slot < N_SLOTS and that bit is set, the bit is cleared and the door is started. Otherwise exit_error pulses and nothing else changes.
- Entry event: evaluated against the bitmap *after* any same-cycle exit clear.
  - If a free slot exists, the lowest free bit is set and the door is started.
  - If no free slot exists, the alarm is started and the bitmap is unchanged.
- Simultaneous entry+exit in one cycle: the exit is applied first. A full lot with a valid exit admits the entering car into the freed slot, or into a lower free slot if one exists.
- Door timer FSM: D_IDLE and D_OPEN.
  - A start in any state loads door_cnt = DOOR_TICKS and enters D_OPEN.
  - In D_OPEN, each tick_en decrements door_cnt. The decrement that reaches 0 returns the FSM to D_IDLE.
  - door_open_light = (state == D_OPEN).
- Alarm timer: identical structure (A_IDLE/A_ALARM, ALARM_TICKS, drives full_light). A new refusal restarts the count.
- Derived outputs are combinational from the registered bitmap:
  - capacity = N_SLOTS − popcount(parking_slots).
  - best_place/best_valid come from the priority encoder.
- Reset values: parking_slots=0, capacity=N_SLOTS, best_place=0, best_valid=1, door_open_light=0, full_light=0, exit_error=0, `*_q`=0, both FSMs idle.

## Timing
- Event latency: the bitmap, door and alarm update at the same clk edge that detects the event; the new value is visible the following cycle.
- capacity, best_place and best_valid follow the bitmap in the same cycle, with no extra register.
- Door on-time: from the event edge through the edge on which the DOOR_TICKS-th subsequent tick_en is sampled. The tick coincident with the start edge is not counted.
- A tick_en and a restart in the same cycle: restart wins, and the counter loads the full value.
- Reset asserted mid-timer or mid-event: everything returns to reset values on that edge, and a sensor still high after reset release counts as a new event.
- The counter width $clog2(max(DOOR_TICKS, ALARM_TICKS)+1) must not wrap.

## Structure
- Package parking_pkg: door/alarm state enum, and constants for N_SLOTS defaults and derived widths.
- Sub-module slot_finder: parametrised lowest-set-bit finder on ~bitmap, giving index plus valid. It is used twice:
  - on the post-exit bitmap, for allocation;
  - on the registered bitmap, for best_place.
- The two timers are a natural shared sub-block (tick_timer, parameter TICKS). This is optional.

## Test plan
- Reset, then 4 entries (N=4) with sensor pulses 3 clk wide -> parking_slots 0001,0011,0111,1111; capacity 3,2,1,0; best_place 1,2,3,0 with best_valid=0 at end; door_open_light on after each entry.
- Full lot, then an entry pulse -> bitmap stays 1111, full_light high for exactly ALARM_TICKS tick_en pulses, door stays off.
- Bitmap 1111, entry and exit (exit_slot=2) rising on the same clk -> bitmap 1111 next cycle, capacity 0, door starts, no alarm.
- Bitmap 0101, exit with exit_slot=1 -> exit_error high for 1 cycle, bitmap unchanged, no door.
- DOOR_TICKS=2, entry, then a second exit event after 1 tick -> door stays on for 2 further ticks, then off; entry_sensor held high for 100 clk -> only one allocation.
- Reset asserted while door_open_light and full_light are high with bitmap 1011 -> next cycle all reset values, capacity=4.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot controller.
// Holds the timer state enums, parameter defaults and the timer counter width helper.
package parking_pkg;

    localparam int DEFAULT_N_SLOTS     = 4;
    localparam int DEFAULT_DOOR_TICKS  = 4;
    localparam int DEFAULT_ALARM_TICKS = 6;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_OPEN = 1'b1
    } door_state_e;

    typedef enum logic {
        A_IDLE  = 1'b0,
        A_ALARM = 1'b1
    } alarm_state_e;

    // Wide enough to hold the larger of the two tick loads without wrapping.
    function automatic int ctr_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/slot_finder.sv
// Lowest-set-bit priority encoder: returns the index of the lowest 1 in free_vec.
// idx is 0 and valid is low when free_vec is all zeros.
module slot_finder #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  free_vec,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // Scanning downward lets the lowest set bit win.
        for (int i = N - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_controller.sv
// N-slot parking controller: occupancy bitmap, lowest-free allocation on entry,
// slot release on exit, and tick-timed door light and full-lot alarm.
module parking_controller
    import parking_pkg::*;
#(
    parameter  int N_SLOTS     = DEFAULT_N_SLOTS,
    parameter  int DOOR_TICKS  = DEFAULT_DOOR_TICKS,
    parameter  int ALARM_TICKS = DEFAULT_ALARM_TICKS,
    localparam int IDX_W       = $clog2(N_SLOTS),
    localparam int CNT_W       = $clog2(N_SLOTS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_en,
    input  logic               entry_sensor,
    input  logic               exit_sensor,
    input  logic [IDX_W-1:0]   exit_slot,
    output logic [N_SLOTS-1:0] parking_slots,
    output logic               door_open_light,
    output logic               full_light,
    output logic [CNT_W-1:0]   capacity,
    output logic [IDX_W-1:0]   best_place,
    output logic               best_valid,
    output logic               exit_error
);

    localparam int CTR_W = ctr_width(DOOR_TICKS, ALARM_TICKS);

    logic [N_SLOTS-1:0] parking_slots_q, parking_slots_d;
    logic               entry_sensor_q, entry_sensor_d;
    logic               exit_sensor_q, exit_sensor_d;
    logic               exit_error_q, exit_error_d;
    door_state_e        door_state_q, door_state_d;
    alarm_state_e       alarm_state_q, alarm_state_d;
    logic [CTR_W-1:0]   door_cnt_q, door_cnt_d;
    logic [CTR_W-1:0]   alarm_cnt_q, alarm_cnt_d;

    logic               entry_ev, exit_ev, exit_in_range, exit_ok;
    logic               door_start, alarm_start;
    logic [N_SLOTS-1:0] post_exit;
    logic [IDX_W-1:0]   alloc_idx;
    logic               alloc_valid;
    logic [CNT_W-1:0]   used_cnt;

    assign entry_ev      = entry_sensor && !entry_sensor_q;
    assign exit_ev       = exit_sensor && !exit_sensor_q;
    assign exit_in_range = (32'(exit_slot) < N_SLOTS);
    assign exit_ok       = exit_ev && exit_in_range && parking_slots_q[exit_slot];

    always_comb begin
        post_exit = parking_slots_q;
        if (exit_ok) begin
            post_exit[exit_slot] = 1'b0;
        end
    end

    // Allocation looks at the bitmap after a same-cycle exit has been applied.
    slot_finder #(.N(N_SLOTS)) u_alloc_finder (
        .free_vec (~post_exit),
        .idx      (alloc_idx),
        .valid    (alloc_valid)
    );

    slot_finder #(.N(N_SLOTS)) u_best_finder (
        .free_vec (~parking_slots_q),
        .idx      (best_place),
        .valid    (best_valid)
    );

    always_comb begin
        entry_sensor_d  = entry_sensor;
        exit_sensor_d   = exit_sensor;
        parking_slots_d = post_exit;
        exit_error_d    = exit_ev && !exit_ok;
        door_start      = exit_ok;
        alarm_start     = 1'b0;
        if (entry_ev) begin
            if (alloc_valid) begin
                parking_slots_d[alloc_idx] = 1'b1;
                door_start                 = 1'b1;
            end else begin
                alarm_start = 1'b1;
            end
        end
    end

    // A start always reloads the full count, even when a tick lands on the same edge.
    always_comb begin
        door_state_d = door_state_q;
        door_cnt_d   = door_cnt_q;
        if (door_start) begin
            door_state_d = D_OPEN;
            door_cnt_d   = CTR_W'(DOOR_TICKS);
        end else if (door_state_q == D_OPEN && tick_en) begin
            door_cnt_d = door_cnt_q - CTR_W'(1);
            if (door_cnt_q == CTR_W'(1)) begin
                door_state_d = D_IDLE;
            end
        end
    end

    always_comb begin
        alarm_state_d = alarm_state_q;
        alarm_cnt_d   = alarm_cnt_q;
        if (alarm_start) begin
            alarm_state_d = A_ALARM;
            alarm_cnt_d   = CTR_W'(ALARM_TICKS);
        end else if (alarm_state_q == A_ALARM && tick_en) begin
            alarm_cnt_d = alarm_cnt_q - CTR_W'(1);
            if (alarm_cnt_q == CTR_W'(1)) begin
                alarm_state_d = A_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            parking_slots_q <= '0;
            entry_sensor_q  <= 1'b0;
            exit_sensor_q   <= 1'b0;
            exit_error_q    <= 1'b0;
            door_state_q    <= D_IDLE;
            door_cnt_q      <= '0;
            alarm_state_q   <= A_IDLE;
            alarm_cnt_q     <= '0;
        end else begin
            parking_slots_q <= parking_slots_d;
            entry_sensor_q  <= entry_sensor_d;
            exit_sensor_q   <= exit_sensor_d;
            exit_error_q    <= exit_error_d;
            door_state_q    <= door_state_d;
            door_cnt_q      <= door_cnt_d;
            alarm_state_q   <= alarm_state_d;
            alarm_cnt_q     <= alarm_cnt_d;
        end
    end

    always_comb begin
        used_cnt = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            used_cnt = used_cnt + CNT_W'(parking_slots_q[i]);
        end
    end

    assign capacity        = CNT_W'(N_SLOTS) - used_cnt;
    assign parking_slots   = parking_slots_q;
    assign exit_error      = exit_error_q;
    assign door_open_light = (door_state_q == D_OPEN);
    assign full_light      = (alarm_state_q == A_ALARM);

endmodule
